// File: rtl/spi_master_if.sv
// Pin-level bundle between the free-running ADC SPI master and the logic around it.
// The master modport drives the serial pins and the parallel receive word.
interface spi_master_if;
  logic        din;
  logic [2:0]  ch_sel;
  logic        sclk;
  logic        dout;
  logic        cs;
  logic [3:0]  count;
  logic [15:0] rx_data;
  logic        rx_valid;

  modport master (
    input  din, ch_sel,
    output sclk, dout, cs, count, rx_data, rx_valid
  );

  modport slave (
    output din, ch_sel,
    input  sclk, dout, cs, count, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_master.sv
// Free-running SPI mode-3 master for a serial ADC: 16-bit frames, channel address out,
// sample word in, one-cycle valid strobe per completed frame. All outputs are flops.
module spi_master #(
  parameter int CLK_DIV   = 2,
  parameter int GAP_TICKS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_END   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic [15:0]   rx_data_q, rx_data_d;
  logic [3:0]    count_q, count_d;
  logic          sclk_q, sclk_d;
  logic          dout_q, dout_d;
  logic          cs_q, cs_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tick_s;

  assign tick_s = (div_q == DIV_LAST);

  always_comb begin
    div_d      = tick_s ? '0 : (div_q + DW'(1));
    state_d    = state_q;
    gap_d      = gap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    count_d    = count_q;
    sclk_d     = sclk_q;
    dout_d     = dout_q;
    cs_d       = cs_q;
    rx_valid_d = 1'b0;

    if (tick_s) begin
      case (state_q)
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            cs_d    = 1'b0;
            count_d = 4'd0;
            tx_d    = {2'b00, bus.ch_sel, 11'b0};
            state_d = ST_START;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        // The tick after cs falls is already the first falling sclk edge.
        ST_START: begin
          sclk_d  = 1'b0;
          dout_d  = tx_q[15];
          tx_d    = {tx_q[14:0], 1'b0};
          state_d = ST_XFER;
        end
        ST_XFER: begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            dout_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            sclk_d  = 1'b1;
            rx_d    = {rx_q[14:0], bus.din};
            count_d = count_q + 4'd1;
            if (count_q == 4'd15) begin
              rx_data_d  = {rx_q[14:0], bus.din};
              rx_valid_d = 1'b1;
              state_d    = ST_END;
            end else begin
              state_d = ST_XFER;
            end
          end
        end
        ST_END: begin
          cs_d    = 1'b1;
          dout_d  = 1'b0;
          sclk_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
        default: begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          dout_d  = 1'b0;
          gap_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_GAP;
      div_q      <= '0;
      gap_q      <= '0;
      tx_q       <= 16'h0000;
      rx_q       <= 16'h0000;
      rx_data_q  <= 16'h0000;
      count_q    <= 4'd0;
      sclk_q     <= 1'b1;
      dout_q     <= 1'b0;
      cs_q       <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      count_q    <= count_d;
      sclk_q     <= sclk_d;
      dout_q     <= dout_d;
      cs_q       <= cs_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.dout     = dout_q;
  assign bus.cs       = cs_q;
  assign bus.count    = count_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default build plus two parameter corners, each with an
// SPI slave model that returns a known word MSB first on falling sclk edges.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_s_n;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   sclk_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if bus0();
  spi_master_if bus1();
  spi_master_if bus2();

  spi_master #(.CLK_DIV(2), .GAP_TICKS(2)) dut0 (.clk(clk), .rst_n(rst_n),   .bus(bus0));
  spi_master #(.CLK_DIV(1), .GAP_TICKS(1)) dut1 (.clk(clk), .rst_n(rst_s_n), .bus(bus1));
  spi_master #(.CLK_DIV(5), .GAP_TICKS(3)) dut2 (.clk(clk), .rst_n(rst_s_n), .bus(bus2));

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] w;
    bit          mid_en;
    logic [2:0]  ch_mid;
    logic [15:0] exp_tx;
    logic [15:0] exp_rx;
    bit          chk_gap;
  } vec_t;

  vec_t        vt [5];
  logic [15:0] wq0 [$];
  logic [15:0] cur_w0;
  logic [15:0] w_sw = 16'h1234;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    n_run++;
    n_fail++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  // Slave for dut0: latch the next queued word at cs fall, present bit 15-count on each sclk fall.
  initial begin
    cur_w0 = 16'h0000;
    forever begin
      @(negedge bus0.cs);
      cur_w0 = (wq0.size() > 0) ? wq0.pop_front() : 16'h0000;
    end
  end

  initial begin
    bus0.din = 1'b0;
    forever begin
      @(negedge bus0.sclk);
      bus0.din = cur_w0[4'd15 - bus0.count];
    end
  end

  initial begin
    bus1.din = 1'b0;
    forever begin
      @(negedge bus1.sclk);
      bus1.din = w_sw[4'd15 - bus1.count];
    end
  end

  initial begin
    bus2.din = 1'b0;
    forever begin
      @(negedge bus2.sclk);
      bus2.din = w_sw[4'd15 - bus2.count];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus0.cs === 1'b1 && bus0.sclk !== 1'b1) sclk_bad++;
    end
  end

  // Runs one dut0 frame; entered any time, it first waits for the gap, then sets ch_sel.
  task automatic run_frame(input logic [2:0] ch, input logic [15:0] w, input bit mid_en,
                           input logic [2:0] ch_mid, output logic [15:0] txb,
                           output logic [15:0] rxw, output int vcnt, output int gap,
                           output int cnt_err, output int per_min, output int per_max,
                           output int vidx);
    int   n;
    int   rises;
    int   last_rise;
    logic sclk_prev;
    n = 0;
    while (bus0.cs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) to_fail("wait_gap");
    bus0.ch_sel = ch;
    wq0.push_back(w);
    gap = 0;
    while (bus0.cs === 1'b1 && gap < 200) begin gap++; @(negedge clk); end
    if (gap >= 200) to_fail("wait_cs_fall");
    txb = 16'h0000; rxw = 16'h0000; vcnt = 0; rises = 0; cnt_err = 0;
    per_min = 999; per_max = 0; last_rise = -1; vidx = -1; sclk_prev = 1'b1; n = 0;
    while (bus0.cs === 1'b0 && n < 200) begin
      if (mid_en && bus0.count == 4'd1) bus0.ch_sel = ch_mid;
      if (bus0.sclk === 1'b1 && sclk_prev === 1'b0) begin
        rises++;
        txb = {txb[14:0], bus0.dout};
        if (bus0.count !== 4'(rises % 16)) cnt_err++;
        if (last_rise >= 0) begin
          if (n - last_rise < per_min) per_min = n - last_rise;
          if (n - last_rise > per_max) per_max = n - last_rise;
        end
        last_rise = n;
      end
      if (bus0.rx_valid === 1'b1) begin
        vcnt++;
        rxw  = bus0.rx_data;
        vidx = (bus0.sclk === 1'b1 && sclk_prev === 1'b0) ? rises : -1;
      end
      sclk_prev = bus0.sclk;
      n++;
      @(negedge clk);
    end
    if (n >= 200) to_fail("wait_cs_rise");
  endtask

  initial begin
    logic [15:0] txb, rxw;
    int vcnt, gap, cnt_err, per_min, per_max, vidx, n, vseen;

    vt[0] = '{3'b101, 16'hA5C3, 1'b1, 3'b010, 16'h2800, 16'hA5C3, 1'b0};
    vt[1] = '{3'b010, 16'hFFFF, 1'b0, 3'b000, 16'h1000, 16'hFFFF, 1'b1};
    vt[2] = '{3'b111, 16'h0000, 1'b0, 3'b000, 16'h3800, 16'h0000, 1'b1};
    vt[3] = '{3'b001, 16'h8001, 1'b0, 3'b000, 16'h0800, 16'h8001, 1'b1};
    vt[4] = '{3'b100, 16'h1234, 1'b0, 3'b000, 16'h2000, 16'h1234, 1'b1};

    rst_n = 1'b0;
    rst_s_n = 1'b0;
    bus0.ch_sel = 3'b000;
    bus1.ch_sel = 3'b011;
    bus2.ch_sel = 3'b110;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_cs", 32'(bus0.cs), 32'd1);
      chk("rst_sclk", 32'(bus0.sclk), 32'd1);
      chk("rst_dout", 32'(bus0.dout), 32'd0);
      chk("rst_count", 32'(bus0.count), 32'd0);
      chk("rst_rx_data", 32'(bus0.rx_data), 32'd0);
      chk("rst_rx_valid", 32'(bus0.rx_valid), 32'd0);
    end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus0.cs === 1'b1 && n < 100);
    chk("first_cs_fall", 32'(n), 32'd4);

    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i].ch, vt[i].w, vt[i].mid_en, vt[i].ch_mid,
                txb, rxw, vcnt, gap, cnt_err, per_min, per_max, vidx);
      chk($sformatf("v%0d_tx", i), 32'(txb), 32'(vt[i].exp_tx));
      chk($sformatf("v%0d_rx", i), 32'(rxw), 32'(vt[i].exp_rx));
      chk($sformatf("v%0d_valid_cnt", i), 32'(vcnt), 32'd1);
      chk($sformatf("v%0d_valid_at_rise", i), 32'(vidx), 32'd16);
      chk($sformatf("v%0d_count_seq_err", i), 32'(cnt_err), 32'd0);
      chk($sformatf("v%0d_sclk_per_min", i), 32'(per_min), 32'd4);
      chk($sformatf("v%0d_sclk_per_max", i), 32'(per_max), 32'd4);
      if (vt[i].chk_gap) chk($sformatf("v%0d_gap", i), 32'(gap), 32'd4);
    end
    chk("sclk_high_when_cs_high", 32'(sclk_bad), 32'd0);

    // Abort a frame at count 7 with an asynchronous reset.
    wq0.push_back(16'hFFFF);
    bus0.ch_sel = 3'b011;
    vseen = 0;
    n = 0;
    while (bus0.cs === 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) to_fail("mid_wait_fall");
    n = 0;
    while (bus0.count !== 4'd7 && n < 200) begin
      if (bus0.rx_valid === 1'b1) vseen++;
      @(negedge clk); n++;
    end
    if (n >= 200) to_fail("mid_wait_count7");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(bus0.cs), 32'd1);
    chk("mid_rst_sclk", 32'(bus0.sclk), 32'd1);
    chk("mid_rst_count", 32'(bus0.count), 32'd0);
    chk("mid_rst_dout", 32'(bus0.dout), 32'd0);
    chk("mid_rst_rx_data", 32'(bus0.rx_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus0.rx_valid === 1'b1) vseen++;
    end
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (bus0.rx_valid === 1'b1) vseen++;
    end while (bus0.cs === 1'b1 && n < 100);
    chk("mid_rst_restart_fall", 32'(n), 32'd4);
    chk("mid_rst_no_valid", 32'(vseen), 32'd0);
    run_frame(3'b110, 16'h5A0F, 1'b0, 3'b000, txb, rxw, vcnt, gap, cnt_err, per_min, per_max, vidx);
    chk("post_rst_tx", 32'(txb), 32'h3000);
    chk("post_rst_rx", 32'(rxw), 32'h5A0F);
    chk("post_rst_valid_cnt", 32'(vcnt), 32'd1);

    // Parameter corners run side by side from a shared release.
    rst_s_n = 1'b1;
    fork
      begin : sw1
        int n1, t0_1, t1_1;
        n1 = 0;
        do begin @(negedge clk); n1++; end while (bus1.cs === 1'b1 && n1 < 100);
        chk("p1_first_fall", 32'(n1), 32'd1);
        t0_1 = cyc;
        n1 = 0;
        while (bus1.rx_valid !== 1'b1 && n1 < 400) begin @(negedge clk); n1++; end
        if (n1 >= 400) to_fail("p1_rx_valid");
        chk("p1_rx", 32'(bus1.rx_data), 32'h1234);
        n1 = 0;
        while (bus1.cs !== 1'b1 && n1 < 400) begin @(negedge clk); n1++; end
        while (bus1.cs === 1'b1 && n1 < 400) begin @(negedge clk); n1++; end
        t1_1 = cyc;
        chk("p1_period", 32'(t1_1 - t0_1), 32'd34);
      end
      begin : sw2
        int n2, t0_2, t1_2;
        n2 = 0;
        do begin @(negedge clk); n2++; end while (bus2.cs === 1'b1 && n2 < 100);
        chk("p2_first_fall", 32'(n2), 32'd15);
        t0_2 = cyc;
        n2 = 0;
        while (bus2.rx_valid !== 1'b1 && n2 < 400) begin @(negedge clk); n2++; end
        if (n2 >= 400) to_fail("p2_rx_valid");
        chk("p2_rx", 32'(bus2.rx_data), 32'h1234);
        n2 = 0;
        while (bus2.cs !== 1'b1 && n2 < 400) begin @(negedge clk); n2++; end
        while (bus2.cs === 1'b1 && n2 < 400) begin @(negedge clk); n2++; end
        t1_2 = cyc;
        chk("p2_period", 32'(t1_2 - t0_2), 32'd180);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Free-running SPI master for an external serial ADC. Continuously runs 16-bit frames on a divided serial clock, shifts a channel address out, captures 16 returned bits, and presents each completed word in parallel with a one-cycle valid strobe. Sits between the board-level ADC pins and the fabric logic that consumes sensor samples.

## Interface

**Parameters**
- `CLK_DIV`, default 2: `clk` cycles per half-period of `sclk`, i.e. per "tick". Minimum 1.
- `GAP_TICKS`, default 2: ticks from the `cs` rising edge to the next `cs` falling edge. Minimum 1.

**Ports**
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `din`, input, 1: serial data from the slave (MISO).
- `ch_sel`, input, 3: ADC channel address for the next frame.
- `sclk`, output, 1: serial clock, CPOL=1 (idles high).
- `dout`, output, 1: serial data to the slave (MOSI).
- `cs`, output, 1: chip select, active low.
- `count`, output, 4: bit index within the current frame.
- `rx_data`, output, 16: last completed received word.
- `rx_valid`, output, 1: one-cycle strobe when `rx_data` updates.

## Operation

- **Mode:** SPI mode 3, MSB first, 16 bits per frame.
  - `dout` changes on `sclk` falling edges.
  - `din` is sampled on `sclk` rising edges.
- **Transmit word:** `{2'b00, ch_sel, 11'b0}`, so the address occupies bits 13:11. `ch_sel` is latched at `cs` assertion; changes mid-frame have no effect until the next frame.
- **States:**
  - GAP (entered from reset): `cs`=1, `sclk`=1.
  - After GAP_TICKS ticks, go to START: `cs`←0, latch `ch_sel` into the transmit shift register.
  - Next tick, go to XFER.
- **XFER:**
  - Each tick toggles `sclk`.
  - On a 1→0 tick: `dout` ← tx[15−`count`].
  - On a 0→1 tick: shift `din` into the receive register and increment `count`.
  - On the rising tick with `count`=15:
    - `count` wraps to 0.
    - `rx_data` ← {rx[14:0], `din`}.
    - `rx_valid`=1 for that one `clk` cycle.
    - Go to END.
- **END:** next tick `cs`←1, `dout`←0; go to GAP. That tick counts as gap tick 1.
- **Reset:** asserting `rst_n` mid-frame aborts immediately; no partial word is reported.
- **Reset values:** `cs`=1, `sclk`=1, `dout`=0, `count`=0, `rx_data`=0, `rx_valid`=0, divider=0.

## Timing

- **Tick:** a single-cycle enable every CLK_DIV `clk` cycles, from a divider counter that counts 0..CLK_DIV−1. The divider is free-running from reset release.
- **Frame, in ticks** (T0 = `cs` fall):
  - Falling `sclk` edges at T1, T3, …, T31.
  - Rising `sclk` edges at T2, T4, …, T32.
  - `cs` rises at T33.
  - Next `cs` fall at T33+GAP_TICKS.
  - Period is 33+GAP_TICKS ticks: 35 ticks = 70 `clk` cycles at defaults.
- **After reset:** first `cs` fall occurs at tick number GAP_TICKS, i.e. `clk` cycle GAP_TICKS×CLK_DIV after `rst_n` deasserts.
- **`sclk` during a frame:** 2×CLK_DIV `clk` cycles per period, 50% duty. It is high whenever `cs`=1.
- **`count`:** 0 from T0 through T2−1; equals k after the k-th rising edge; returns to 0 at T32.
- **`rx_valid` latency:** asserted in the same `clk` cycle that `sclk` rises for the 16th time. Exactly one strobe per frame.
- **Setup/hold:** `dout` is stable for a full half-period before and after each rising `sclk` edge.
- **Registered outputs:** all outputs are registered; no combinational path from input to output.

## Test plan

- **Reset values and first frame:** hold `rst_n`=0 for 5 cycles, then release.
  - All reset values hold while `rst_n`=0.
  - `cs` falls at cycle 4 after release (defaults).
  - `sclk` period is 4 `clk` cycles.
- **Transmit pattern:** `ch_sel`=3'b101 → `dout` across the 16 falling edges = 0010100000000000.
  - Change `ch_sel` to 3'b010 mid-frame → the current frame is unchanged and the next frame carries 0001000000000000.
- **Receive path:** drive `din` with 16'hA5C3, MSB first, updated on falling edges.
  - `rx_data`=16'hA5C3.
  - `rx_valid` high for exactly 1 cycle at the 16th rising edge.
  - `count` goes 0→1→…→15→0.
- **Back-to-back frames:** run 3 frames with `din` words 16'hFFFF, 16'h0000, 16'h8001.
  - Each word is reported in order.
  - `cs` is high for exactly GAP_TICKS ticks (4 `clk` cycles) between frames.
  - `sclk` stays high while `cs`=1.
- **Reset mid-frame:** assert `rst_n` at `count`=7.
  - `cs`=1, `sclk`=1, `count`=0 asynchronously.
  - No `rx_valid` pulse.
  - `rx_data` is 0.
  - Normal framing restarts after release.
- **Parameter sweep:** CLK_DIV=1 with GAP_TICKS=1, and CLK_DIV=5 with GAP_TICKS=3.
  - Frame period is 34 and 180 `clk` cycles respectively.
  - Loopback of 16'h1234 is correct in both.
